// File: rtl/bd_rx_sync_fifo_if.sv
// Bundle of the two channels that bd_rx_sync_fifo terminates.
//   Upstream 4-phase bundled-data side: lreq, lack, ldata.
//   Downstream synchronous side: out_valid, out_ready, out_data, count.
// modport master : the receiver FIFO (acks upstream, sources the valid/ready stream).
// modport slave  : the surrounding environment (upstream BD stage + downstream consumer).
interface bd_rx_sync_fifo_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int COUNT_W = $clog2(DEPTH + 1);

   logic               lreq;
   logic               lack;
   logic [WIDTH-1:0]   ldata;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic [COUNT_W-1:0] count;

   modport master (
      input  lreq, ldata, out_ready,
      output lack, out_valid, out_data, count
   );

   modport slave (
      output lreq, ldata, out_ready,
      input  lack, out_valid, out_data, count
   );
endinterface

// File: rtl/bd_rx_sync_fifo.sv
// Clocked receiver for a 4-phase bundled-data channel. lreq is synchronized
// into clk, each token is captured into a show-ahead FIFO and presented on a
// valid/ready port. Backpressure to the async pipeline is applied by not
// raising lack while the FIFO is full.
// Ports:
//   clk  - receiver clock
//   rst  - synchronous, active-high reset
//   bus  - bd_rx_sync_fifo_if.master (lreq/lack/ldata in, out_valid/out_ready/
//          out_data/count out)
module bd_rx_sync_fifo #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   bd_rx_sync_fifo_if.master    bus
);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int COUNT_W = $clog2(DEPTH + 1);

   typedef enum logic {
      IDLE,
      ACKED
   } state_t;

   state_t               state, state_nxt;
   logic [SYNC_STAGES-1:0] sync;
   logic                 lreq_s;
   logic                 lack_q, lack_nxt;
   logic                 push, pop, full;
   logic [PTR_W-1:0]     wptr, rptr;
   logic [COUNT_W-1:0]   count_q;
   logic [WIDTH-1:0]     mem [DEPTH];

   // lreq synchronizer; only lreq is metastability-exposed, ldata is
   // bundled and already stable by the time lreq_s goes high.
   always_ff @(posedge clk) begin
      if (rst) sync <= '0;
      else     sync <= {sync[SYNC_STAGES-2:0], bus.lreq};
   end

   assign lreq_s = sync[SYNC_STAGES-1];

   // Fullness uses registered count: a pop this cycle frees space only
   // from the next edge onward.
   assign full = (count_q == COUNT_W'(DEPTH));
   assign pop  = (count_q != '0) && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         lack_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         lack_q <= lack_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      lack_nxt  = lack_q;
      push      = 1'b0;
      case (state)
         IDLE: begin
            if (lreq_s && !full) begin
               push      = 1'b1;
               lack_nxt  = 1'b1;
               state_nxt = ACKED;
            end
         end
         ACKED: begin
            if (!lreq_s) begin
               lack_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: begin
            lack_nxt  = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr    <= '0;
         rptr    <= '0;
         count_q <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_W'(1);
         if (pop)  rptr <= rptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + COUNT_W'(1);
            2'b01:   count_q <= count_q - COUNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is not reset; contents are meaningless while count is zero.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= bus.ldata;
   end

   assign bus.lack      = lack_q;
   assign bus.out_valid = (count_q != '0);
   assign bus.out_data  = mem[rptr];
   assign bus.count     = count_q;
endmodule

// File: tb/tb_bd_rx_sync_fifo.sv
// Self-checking bench for bd_rx_sync_fifo. Every token issued upstream is
// queued as the expected output; a negedge monitor pops and compares each
// time the DUT hands a token downstream. Directed checks cover handshake
// latency, stall, simultaneous push/pop, wrap-around and reset.
module tb_bd_rx_sync_fifo;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int SYNC  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [WIDTH-1:0] exp_q[$];

   always #5 clk = ~clk;

   bd_rx_sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   bd_rx_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: a token leaves the DUT on the edge following a
   // negedge where valid and ready are both high.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_token: got %0h, expected none", bus.out_data);
         end else begin
            logic [WIDTH-1:0] e;
            e = exp_q.pop_front();
            if (bus.out_data !== e) begin
               errors++;
               $display("FAIL token_order: got %0h, expected %0h", bus.out_data, e);
            end
         end
      end
   end

   task automatic raise(input logic [WIDTH-1:0] d);
      bus.ldata = d;
      bus.lreq  = 1'b1;
      exp_q.push_back(d);
   endtask

   task automatic wait_lack(input logic val, input int max_edges, output int n);
      n = 0;
      while (bus.lack !== val && n < max_edges) begin
         tick();
         n++;
      end
      check("lack_wait_bound", {31'd0, bus.lack}, {31'd0, val});
   endtask

   task automatic send_token(input logic [WIDTH-1:0] d, input int bound);
      int n;
      raise(d);
      wait_lack(1'b1, bound, n);
      bus.lreq = 1'b0;
      wait_lack(1'b0, bound, n);
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      bus.out_ready = 1'b1;
      while (bus.count != 0 && n < bound) begin
         tick();
         n++;
      end
      bus.out_ready = 1'b0;
      check("drain_count", 32'(bus.count), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  n;
      bit  stalled_ack;
      bit  done;
      int  maxc;

      bus.lreq      = 1'b0;
      bus.ldata     = '0;
      bus.out_ready = 1'b0;

      // Reset
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("reset_lack", {31'd0, bus.lack}, 32'd0);
      check("reset_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset_count", 32'(bus.count), 32'd0);

      // Single token: lack after SYNC+1 edges in both directions
      raise(8'h5A);
      wait_lack(1'b1, 10, n);
      check("rise_latency", 32'(n), 32'(SYNC + 1));
      check("single_valid", {31'd0, bus.out_valid}, 32'd1);
      check("single_data", 32'(bus.out_data), 32'h5A);
      check("single_count", 32'(bus.count), 32'd1);
      bus.lreq = 1'b0;
      wait_lack(1'b0, 10, n);
      check("fall_latency", 32'(n), 32'(SYNC + 1));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("single_pop_count", 32'(bus.count), 32'd0);

      // Full stall
      for (int i = 1; i <= 4; i++) send_token(8'(i), 20);
      check("full_count", 32'(bus.count), 32'd4);
      raise(8'h05);
      stalled_ack = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.lack) stalled_ack = 1'b1;
      end
      check("full_stall_lack", {31'd0, stalled_ack}, 32'd0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("full_pop_count", 32'(bus.count), 32'd3);
      wait_lack(1'b1, 10, n);
      check("unstall_latency", 32'(n), 32'd1);
      check("unstall_count", 32'(bus.count), 32'd4);
      check("unstall_head", 32'(bus.out_data), 32'h02);
      bus.lreq = 1'b0;
      wait_lack(1'b0, 10, n);
      drain(10);

      // Simultaneous push and pop
      send_token(8'hAA, 20);
      check("pp_pre_count", 32'(bus.count), 32'd1);
      raise(8'hBB);
      tick();
      tick();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("pp_lack", {31'd0, bus.lack}, 32'd1);
      check("pp_count", 32'(bus.count), 32'd1);
      check("pp_data", 32'(bus.out_data), 32'hBB);
      bus.lreq = 1'b0;
      wait_lack(1'b0, 10, n);
      drain(10);

      // Wrap-around with random backpressure
      done = 1'b0;
      maxc = 0;
      fork
         begin
            for (int i = 0; i < 10; i++) send_token(8'(16 + i), 80);
            done = 1'b1;
         end
         begin
            while (!done) begin
               bus.out_ready = 1'($urandom_range(0, 1));
               tick();
               if (int'(bus.count) > maxc) maxc = int'(bus.count);
            end
         end
      join
      drain(20);
      check("wrap_max_count_ok", {31'd0, (maxc <= DEPTH)}, 32'd1);
      check("wrap_all_delivered", 32'(exp_q.size()), 32'd0);

      // Reset mid-handshake
      send_token(8'h31, 20);
      send_token(8'h32, 20);
      raise(8'h77);
      wait_lack(1'b1, 10, n);
      check("mid_pre_count", 32'(bus.count), 32'd3);
      rst = 1'b1;
      tick();
      check("mid_rst_lack", {31'd0, bus.lack}, 32'd0);
      check("mid_rst_count", 32'(bus.count), 32'd0);
      check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      rst = 1'b0;
      exp_q.delete();
      // lreq still high: taken as a fresh token
      exp_q.push_back(8'h77);
      wait_lack(1'b1, 10, n);
      check("post_rst_latency", 32'(n), 32'(SYNC + 1));
      check("post_rst_data", 32'(bus.out_data), 32'h77);
      bus.lreq = 1'b0;
      wait_lack(1'b0, 10, n);
      drain(10);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bd_rx_sync_fifo.md
# bd_rx_sync_fifo

Clocked receiver that terminates a 4-phase bundled-data channel (lreq/lack/ldata) coming out of the asynchronous adder/subtractor pipeline. It brings lreq into the `clk` domain through a synchronizer and captures each token into a small FIFO. It then presents the tokens on a synchronous valid/ready port to the clocked neuron/NoC logic downstream. Backpressure reaches the async pipeline by withholding lack.

## Interface
- WIDTH, 8, token data width; matches the upstream rdata width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, flip-flop stages in the lreq synchronizer; at least 2.

- clk  input  1  receiver clock.
- rst  input  1  reset, synchronous, active-high.
- lreq  input  1  async 4-phase request from the upstream BD stage.
- lack  output  1  4-phase acknowledge to upstream; registered.
- ldata  input  WIDTH  bundled data; stable from before lreq rises until lack is seen high.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  head-of-FIFO token (show-ahead).
- count  output  $clog2(DEPTH+1)  current occupancy.

## Operation
- **Synchronizer.** lreq passes through SYNC_STAGES flops; the last stage is lreq_s. All flops clear on reset.
- **FSM states.** IDLE and ACKED.
  - IDLE, with lreq_s=1 and count<DEPTH:
    - write ldata to mem[wptr];
    - wptr <= wptr+1, wrapping mod DEPTH;
    - lack <= 1;
    - next state ACKED.
  - IDLE, with lreq_s=1 and count==DEPTH: stay in IDLE, lack held 0 (stall).
  - IDLE, with lreq_s=0: stay in IDLE.
  - ACKED, with lreq_s=0: lack <= 0, next state IDLE.
  - ACKED, otherwise: hold.
- **Fullness check.** The full test uses the registered count. A pop in the same cycle does not enable a push in that cycle; the push happens on the next edge.
- **Pop.** When out_valid & out_ready: rptr <= rptr+1 (wrapping). out_data is always mem[rptr].
- **Count.**
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: count unchanged, with both pointers advancing.
- **Output flags.** out_valid = (count != 0). A pop while empty is ignored.
- **Token accounting.** One token per full 4-phase cycle (lreq up, lack up, lreq down, lack down). A second rise of lreq is not accepted until lack has returned to 0, which the upstream protocol already guarantees.
- **Data width.** ldata is captured unmodified; there is no arithmetic on it.

## Timing
- **Reset values.** On the edge with rst=1:
  - lack=0, out_valid=0, count=0;
  - wptr=0, rptr=0, synchronizer=0, state IDLE;
  - out_data = mem[0], whose value is don't-care.
- **Reset mid-handshake.** lack drops on the reset edge and the stored tokens are discarded. Upstream is reset by the same rst. An lreq still high after reset is taken as a new token.
- **lreq rise to lack rise.** SYNC_STAGES+1 clock edges when not full. The same edge sets count+1 and out_valid=1, with out_data showing the token if the FIFO was empty.
- **lreq fall to lack fall.** SYNC_STAGES+1 edges.
- **Maximum acceptance rate.** One token per 2·(SYNC_STAGES+1) cycles, plus upstream delay.
- **Output side.** Zero-latency show-ahead; a pop takes effect on the clock edge.
- **Bundling constraint.** ldata is sampled at least SYNC_STAGES edges after lreq rises, so it needs no synchronization. Only lreq is metastability-exposed.

## Test plan
- **Reset.** Assert rst for 2 cycles with lreq=0 -> lack=0, out_valid=0, count=0.
- **Single token.** SYNC_STAGES=2, ldata=0x5A, lreq rises -> lack=1 on the 3rd edge with out_valid=1, out_data=0x5A, count=1. Then drop lreq -> lack=0 three edges later.
- **Full stall.** out_ready=0, send 0x01..0x04 -> count=4. Then present 0x05 -> lack stays 0. Pulse out_ready for 1 cycle -> 0x01 is popped, lack rises one edge later, and count returns to 4 with head 0x02.
- **Simultaneous push/pop.** count=1 with head 0xAA, out_ready=1 on the same edge that captures 0xBB -> count stays 1 and out_data=0xBB.
- **Wrap-around.** Stream 10 tokens 0x10..0x19 with out_ready random at 50% -> output order is 0x10..0x19 exactly, with no loss or duplication, and count never exceeds 4.
- **Reset mid-operation.** With lack=1 and count=3, assert rst -> on the next edge lack=0, count=0, out_valid=0.
